// File: rtl/hub75e_bcm_scheduler_pkg.sv
// ============================================================================
// Module      : hub75e_pkg
// Description : Shared state encoding and plane timing helper for the HUB75E
//               binary-coded-modulation scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hub75e_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        BLANK   = 3'd2,
        LATCH   = 3'd3,
        DISPLAY = 3'd4
    } state_t;

    localparam int c_ROW_W = 5;

    // OE-low cycles for one bit plane: the LSB plane gets the base time and
    // every higher plane doubles it.
    function automatic int display_cycles(input int base, input int plane);
        return base << plane;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hub75e_bcm_scheduler_timer.sv
// ============================================================================
// Module      : hub75e_bcm_timer
// Description : Loadable down-counter with a done flag; times the OE window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hub75e_bcm_timer #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    // Loading N-1 makes done assert on the Nth cycle after the load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/hub75e_bcm_scheduler.sv
// ============================================================================
// Module      : hub75e_bcm_scheduler
// Description : HUB75E 1/32-scan driver with binary-coded modulation; fetches
//               top/bottom pixel pairs and sequences shift, latch and OE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hub75e_bcm_scheduler
    import hub75e_pkg::*;
#(
    parameter int CLK_MHZ        = 50,
    parameter int SCREEN_WIDTH   = 64,
    parameter int SCREEN_HEIGHT  = 64,
    parameter int W_COLOR        = 4,
    parameter int BASE_OE_CYCLES = 8,
    parameter int W_X            = $clog2(SCREEN_WIDTH),
    parameter int W_ROW          = $clog2(SCREEN_HEIGHT / 2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    output logic [W_X-1:0]     x,
    output logic [W_ROW-1:0]   row,
    input  logic [W_COLOR-1:0] top_red,
    input  logic [W_COLOR-1:0] top_green,
    input  logic [W_COLOR-1:0] top_blue,
    input  logic [W_COLOR-1:0] bot_red,
    input  logic [W_COLOR-1:0] bot_green,
    input  logic [W_COLOR-1:0] bot_blue,
    output logic               ck,
    output logic               oe,
    output logic               st,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d,
    output logic               e,
    output logic               r1,
    output logic               g1,
    output logic               b1,
    output logic               r2,
    output logic               g2,
    output logic               b2,
    output logic               frame_done
);

    localparam int c_DISP_MAX = display_cycles(BASE_OE_CYCLES, W_COLOR - 1);
    localparam int c_CNT_W    = $clog2(c_DISP_MAX + 1);
    localparam int c_SH_LAST  = 2 * SCREEN_WIDTH;
    localparam int c_SH_W     = $clog2(c_SH_LAST + 1);
    localparam int c_PL_W     = (W_COLOR > 1) ? $clog2(W_COLOR) : 1;

    if (W_ROW != c_ROW_W || CLK_MHZ < 1) begin : g_param_guard
        $error("hub75e_bcm_scheduler: unsupported parameter set");
    end

    state_t              r_state;
    state_t              w_state_nxt;

    logic [c_SH_W-1:0]   r_sh_cnt;
    logic [W_X-1:0]      r_x;
    logic [W_ROW-1:0]    r_row;
    logic [c_PL_W-1:0]   r_plane;

    logic                w_sh_last;
    logic                w_last_plane;
    logic                w_last_row;
    logic                w_tmr_done;
    logic [c_CNT_W-1:0]  w_tmr_value;

    logic                r_ck;
    logic                r_oe;
    logic                r_st;
    logic [W_ROW-1:0]    r_addr;
    logic [5:0]          r_rgb;
    logic                r_frame_done;

    logic                w_ck_nxt;
    logic                w_oe_nxt;
    logic                w_st_nxt;
    logic [W_ROW-1:0]    w_addr_nxt;
    logic [5:0]          w_rgb_nxt;
    logic                w_frame_done_nxt;

    assign w_sh_last    = (r_sh_cnt == c_SH_W'(c_SH_LAST));
    assign w_last_plane = (r_plane == c_PL_W'(W_COLOR - 1));
    assign w_last_row   = (r_row == W_ROW'(SCREEN_HEIGHT / 2 - 1));
    assign w_tmr_value  = c_CNT_W'(display_cycles(BASE_OE_CYCLES, int'(r_plane)) - 1);

    hub75e_bcm_timer #(
        .CNT_W   (c_CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (r_state == LATCH),
        .i_value (w_tmr_value),
        .o_done  (w_tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (enable) w_state_nxt = SHIFT;
            SHIFT:   if (w_sh_last) w_state_nxt = BLANK;
            BLANK:   w_state_nxt = LATCH;
            LATCH:   w_state_nxt = DISPLAY;
            DISPLAY: begin
                if (w_tmr_done) begin
                    // A row is never abandoned half way: enable only parks us
                    // once the final plane has been shown.
                    w_state_nxt = (w_last_plane && !enable) ? IDLE : SHIFT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Odd SHIFT cycles capture a returned pixel and move x on; even cycles
    // (after the fill cycle) raise ck on the data captured the cycle before.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_cnt <= '0;
            r_x      <= '0;
            r_row    <= '0;
            r_plane  <= '0;
        end else begin
            if (r_state == SHIFT) begin
                r_sh_cnt <= w_sh_last ? '0 : r_sh_cnt + c_SH_W'(1);
                if (r_sh_cnt[0]) begin
                    r_x <= (r_x == W_X'(SCREEN_WIDTH - 1)) ? '0 : r_x + W_X'(1);
                end
            end
            if (r_state == DISPLAY && w_tmr_done) begin
                if (w_last_plane) begin
                    r_plane <= '0;
                    r_row   <= r_row + W_ROW'(1);
                end else begin
                    r_plane <= r_plane + c_PL_W'(1);
                end
            end
        end
    end

    // oe and st follow the next state so they line up with LATCH/DISPLAY
    // exactly; ck and pixel data trail the shift counter by one cycle.
    always_comb begin
        w_ck_nxt         = 1'b0;
        w_oe_nxt         = (w_state_nxt != DISPLAY);
        w_st_nxt         = (w_state_nxt == LATCH);
        w_addr_nxt       = r_addr;
        w_rgb_nxt        = r_rgb;
        w_frame_done_nxt = 1'b0;
        case (r_state)
            SHIFT: begin
                if (r_sh_cnt[0]) begin
                    w_rgb_nxt = {top_red[r_plane], top_green[r_plane], top_blue[r_plane],
                                 bot_red[r_plane], bot_green[r_plane], bot_blue[r_plane]};
                end else if (r_sh_cnt != '0) begin
                    w_ck_nxt = 1'b1;
                end
            end
            BLANK:   w_addr_nxt = r_row;
            DISPLAY: w_frame_done_nxt = w_tmr_done && w_last_plane && w_last_row;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ck         <= 1'b0;
            r_oe         <= 1'b1;
            r_st         <= 1'b0;
            r_addr       <= '0;
            r_rgb        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_ck         <= w_ck_nxt;
            r_oe         <= w_oe_nxt;
            r_st         <= w_st_nxt;
            r_addr       <= w_addr_nxt;
            r_rgb        <= w_rgb_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign x                          = r_x;
    assign row                        = r_row;
    assign ck                         = r_ck;
    assign oe                         = r_oe;
    assign st                         = r_st;
    assign {e, d, c, b, a}            = r_addr;
    assign {r1, g1, b1, r2, g2, b2}   = r_rgb;
    assign frame_done                 = r_frame_done;

endmodule

`default_nettype wire
